index_batch_scheduler: RTL
==========================

Name: index_batch_scheduler

Overview:
- Sequences sparse-index batches from the index buffer into the index_parser and PE array.
- On a job start, it reads one buffer word per batch. Each word holds PE_NUMBER packed row indices and PE_NUMBER packed col indices.
- Each batch is presented to the parser together with the remaining-nonzero count, under a valid/ready handshake towards the PE array.
- Loops until all nonzeros are issued, then pulses done.

Parameters:
- PE_NUMBER, 32, PEs per batch (power of two).
- LOG2_HEIGHT, 4, row index width.
- LOG2_PES, 5, col index width; PE_NUMBER == 2**LOG2_PES.
- LOG2_K, 5, with LOG2_HEIGHT sets count width CNT_W = LOG2_HEIGHT+LOG2_K.
- ADDR_W, 10, index buffer address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  job start pulse; sampled only in IDLE
- i_nnz_total  in  CNT_W  nonzeros in job; sampled with i_start
- i_base_addr  in  ADDR_W  first buffer word; sampled with i_start
- o_rd_en  out  1  buffer read strobe
- o_rd_addr  out  ADDR_W  buffer read address
- i_rd_row  in  PE_NUMBER*LOG2_HEIGHT  row indices; valid the cycle after o_rd_en
- i_rd_col  in  PE_NUMBER*LOG2_PES  col indices; valid the cycle after o_rd_en
- o_row_index  out  PE_NUMBER*LOG2_HEIGHT  registered batch rows to parser
- o_col_index  out  PE_NUMBER*LOG2_PES  registered batch cols to parser
- o_remain_count  out  CNT_W  nonzeros remaining, this batch included
- o_valid  out  1  batch valid
- i_ready  in  1  PE array accepts batch
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle job-complete pulse

Behaviour:
- Clocking and reset: single clock i_clk; i_rst is synchronous and active-high. In reset, state=IDLE and every output is 0: o_rd_en, o_rd_addr, o_row_index, o_col_index, o_remain_count, o_valid, o_busy, o_done.
- Reset during any state: return to IDLE next edge. Any in-flight batch is dropped and no o_done is issued.
- FSM states: IDLE, FETCH, WAIT, ISSUE, DONE.
- IDLE:
  - i_start=1 and i_nnz_total!=0: latch remain=i_nnz_total and addr=i_base_addr; go to FETCH.
  - i_start=1 and i_nnz_total==0: go to DONE; no read and no batch.
- FETCH: o_rd_en=1 and o_rd_addr=addr for exactly one cycle; go to WAIT.
- WAIT: capture i_rd_row/i_rd_col into o_row_index/o_col_index; set o_remain_count=remain; go to ISSUE.
- ISSUE:
  - o_valid=1. o_row_index, o_col_index and o_remain_count are held stable until the cycle with o_valid&&i_ready.
  - On handshake with remain<=PE_NUMBER: go to DONE.
  - On handshake otherwise: remain -= PE_NUMBER, addr += 1 (wraps modulo 2**ADDR_W), go to FETCH.
  - o_valid drops the cycle after handshake.
- DONE: o_done=1 for one cycle; go to IDLE. o_busy=0 in this cycle's successor.
- Timing: i_start sampled at edge N gives o_rd_en high in cycle N+1 and o_valid high from cycle N+3. With i_ready held high, throughput is one batch per 3 cycles.
- i_start outside IDLE is ignored; the latched parameters are unchanged.
- o_remain_count is never 0 while o_valid=1. Values >=PE_NUMBER mean a full batch to the parser.
- No arithmetic underflow: subtraction happens only when remain>PE_NUMBER.

Optional Feature:
- Macro: INDEX_SCHED_ABORT_EN.
- Defined: adds input i_abort (1 bit) and output o_aborted (1 bit).
  - i_abort=1 in FETCH, WAIT, ISSUE or DONE: state becomes IDLE next edge, o_valid=0, o_rd_en=0, o_done is not pulsed, and o_aborted pulses for one cycle.
  - i_abort in IDLE has no effect.
  - i_abort has priority over a same-cycle handshake; that batch counts as not accepted.
  - i_rst has priority over i_abort.
- Undefined: neither port exists and behaviour is exactly as above.

Test Plan:
- nnz=70, base=0x010, i_ready=1 -> reads at 0x010, 0x011, 0x012; o_remain_count 70, 38, 6; o_done one cycle after the third handshake; first o_valid 3 cycles after start.
- nnz=32 -> one read at base, one batch with o_remain_count=32, then o_done; nnz=33 -> two batches, 33 then 1.
- nnz=0 -> no o_rd_en and no o_valid; o_done exactly 1 cycle after the start edge; o_busy high for that one cycle only.
- Backpressure: nnz=40, i_ready low 5 cycles in ISSUE -> o_valid and data stable all 5 cycles; exactly 2 batches total.
- Wrap/robustness: base=2**ADDR_W-1, nnz=64 -> second read at address 0. i_start with nnz=5 during busy -> ignored.
- i_rst pulsed in WAIT -> all outputs 0 next cycle, no o_done, and a new job then runs correctly. With INDEX_SCHED_ABORT_EN: i_abort in ISSUE -> o_aborted pulse, no o_done.

Source files
------------

// File: rtl/index_batch_scheduler.sv
// Index batch scheduler: fetches packed row/col index words and issues them as PE batches.
// Optional abort support is compiled in with `define INDEX_SCHED_ABORT_EN.
module index_batch_scheduler #(
    parameter int PE_NUMBER   = 32,
    parameter int LOG2_HEIGHT = 4,
    parameter int LOG2_PES    = 5,
    parameter int LOG2_K      = 5,
    parameter int ADDR_W      = 10,
    localparam int CNT_W      = LOG2_HEIGHT + LOG2_K,
    localparam int ROW_W      = PE_NUMBER * LOG2_HEIGHT,
    localparam int COL_W      = PE_NUMBER * LOG2_PES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_nnz_total,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [ROW_W-1:0]  i_rd_row,
    input  logic [COL_W-1:0]  i_rd_col,
    output logic [ROW_W-1:0]  o_row_index,
    output logic [COL_W-1:0]  o_col_index,
    output logic [CNT_W-1:0]  o_remain_count,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done
`ifdef INDEX_SCHED_ABORT_EN
   ,input  logic              i_abort,
    output logic              o_aborted
`endif
);

    localparam logic [CNT_W-1:0] PE_CNT = CNT_W'(PE_NUMBER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_en;
    logic                valid;
    logic                done;
`ifdef INDEX_SCHED_ABORT_EN
    logic                aborted_q, aborted_d;
`endif

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        addr_d   = addr_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        rd_en    = 1'b0;
        valid    = 1'b0;
        done     = 1'b0;
`ifdef INDEX_SCHED_ABORT_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_nnz_total != '0) begin
                        remain_d = i_nnz_total;
                        addr_d   = i_base_addr;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                row_d   = i_rd_row;
                col_d   = i_rd_col;
                cnt_d   = remain_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                valid = 1'b1;
                if (i_ready) begin
                    // Subtract only while more than one batch remains.
                    if (remain_q <= PE_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        remain_d = remain_q - PE_CNT;
                        addr_d   = addr_q + ADDR_W'(1);
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef INDEX_SCHED_ABORT_EN
        // Abort wins over a same-cycle handshake: the batch is not accepted.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            remain_d  = remain_q;
            addr_d    = addr_q;
            rd_en     = 1'b0;
            valid     = 1'b0;
            done      = 1'b0;
            aborted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
`ifdef INDEX_SCHED_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
`ifdef INDEX_SCHED_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign o_rd_en        = rd_en;
    assign o_rd_addr      = addr_q;
    assign o_row_index    = row_q;
    assign o_col_index    = col_q;
    assign o_remain_count = cnt_q;
    assign o_valid        = valid;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = done;
`ifdef INDEX_SCHED_ABORT_EN
    assign o_aborted      = aborted_q;
`endif

endmodule
